// File: rtl/speed_window_ctrl.sv
// Hall-based BLDC speed gate: synchronises hall codes, counts commutations per fixed window.
// Optional DIRECTION_EN macro adds rotation direction output and skipped-state fault detection.
module speed_window_ctrl #(
    parameter int DIV_WIDTH     = 13,
    parameter int WINDOW        = 435,
    parameter int CWIDTH        = 11,
    parameter int STALL_WINDOWS = 4
) (
    input  logic              clock_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        hall_effect,
    input  logic              fault_clear,
    output logic [CWIDTH-1:0] comm_count,
    output logic              count_valid,
    output logic              window_busy,
    output logic              stall,
    output logic              hall_fault,
    output logic              direction
);

    localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int SW = $clog2(STALL_WINDOWS + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_LATCH   = 2'd3;

    logic [2:0]           sync1, sync2, last_code;
    logic [1:0]           vld_pipe;
    logic                 code_seen, code_legal, hall_edge, illegal_code, skip_fault;
    logic [1:0]           state;
    logic [DIV_WIDTH-1:0] presc;
    logic [TW-1:0]        tick_cnt;
    logic [CWIDTH-1:0]    comm_cnt, comm_next;
    logic [SW-1:0]        stall_cnt;
    logic                 tick, window_end;

    // vld_pipe marks when sync2 holds a real pin sample, so the reset zeros are not seen as code 000
    always_ff @(posedge clock_sys or posedge reset) begin
        if (reset) begin
            sync1    <= 3'b000;
            sync2    <= 3'b000;
            vld_pipe <= 2'b00;
        end else begin
            sync1    <= hall_effect;
            sync2    <= sync1;
            vld_pipe <= {vld_pipe[0], 1'b1};
        end
    end

    assign code_seen    = vld_pipe[1];
    assign code_legal   = code_seen && (sync2 != 3'b000) && (sync2 != 3'b111);
    assign illegal_code = code_seen && !code_legal;
    assign hall_edge    = code_legal && (sync2 != last_code) && (last_code != 3'b000);

`ifdef DIRECTION_EN
    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        case (code)
            3'b001:  fwd_next = 3'b011;
            3'b011:  fwd_next = 3'b010;
            3'b010:  fwd_next = 3'b110;
            3'b110:  fwd_next = 3'b100;
            3'b100:  fwd_next = 3'b101;
            3'b101:  fwd_next = 3'b001;
            default: fwd_next = 3'b000;
        endcase
    endfunction

    logic fwd_step, rev_step;
    assign fwd_step   = (fwd_next(last_code) == sync2);
    assign rev_step   = (fwd_next(sync2) == last_code);
    assign skip_fault = hall_edge && !fwd_step && !rev_step;

    always_ff @(posedge clock_sys or posedge reset) begin
        if (reset)
            direction <= 1'b0;
        else if (hall_edge && fwd_step)
            direction <= 1'b1;
        else if (hall_edge && rev_step)
            direction <= 1'b0;
    end
`else
    assign skip_fault = 1'b0;
    assign direction  = 1'b0;
`endif

    always_ff @(posedge clock_sys or posedge reset) begin
        if (reset) begin
            last_code  <= 3'b000;
            hall_fault <= 1'b0;
        end else begin
            if (code_legal)
                last_code <= sync2;
            // a new fault in the same cycle wins over the clear
            if (illegal_code || skip_fault)
                hall_fault <= 1'b1;
            else if (fault_clear)
                hall_fault <= 1'b0;
        end
    end

    assign tick       = &presc;
    assign window_end = (state == S_MEASURE) && tick && (tick_cnt == TW'(WINDOW - 1));
    assign comm_next  = (&comm_cnt) ? comm_cnt : comm_cnt + CWIDTH'(hall_edge);

    always_ff @(posedge clock_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (!enable) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state <= S_ARM;
                S_ARM:     state <= S_MEASURE;
                S_MEASURE: state <= window_end ? S_LATCH : S_MEASURE;
                default:   state <= S_MEASURE;
            endcase
        end
    end

    // LATCH is prescaler count 0 of the next window, keeping LATCH-to-LATCH at WINDOW ticks
    always_ff @(posedge clock_sys or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            tick_cnt <= '0;
            comm_cnt <= '0;
        end else if (!enable || state == S_IDLE || state == S_ARM) begin
            presc    <= '0;
            tick_cnt <= '0;
            comm_cnt <= '0;
        end else if (state == S_MEASURE) begin
            presc <= presc + DIV_WIDTH'(1);
            if (tick)
                tick_cnt <= window_end ? '0 : tick_cnt + TW'(1);
            comm_cnt <= window_end ? '0 : comm_next;
        end else begin
            presc    <= presc + DIV_WIDTH'(1);
            tick_cnt <= '0;
            comm_cnt <= CWIDTH'(hall_edge);
        end
    end

    always_ff @(posedge clock_sys or posedge reset) begin
        if (reset) begin
            comm_count <= '0;
            stall_cnt  <= '0;
        end else if (!enable || state == S_IDLE) begin
            stall_cnt <= '0;
        end else if (window_end) begin
            comm_count <= comm_next;
            if (comm_next != '0)
                stall_cnt <= '0;
            else if (stall_cnt != SW'(STALL_WINDOWS))
                stall_cnt <= stall_cnt + SW'(1);
        end
    end

    assign count_valid = (state == S_LATCH);
    assign window_busy = (state == S_ARM) || (state == S_MEASURE);
    assign stall       = (stall_cnt == SW'(STALL_WINDOWS));

endmodule

// File: tb/tb_speed_window_ctrl.sv
// Bench for speed_window_ctrl: directed window/fault/saturation cases plus random hall traffic
// checked every cycle against a window-age based reference model.
module tb_speed_window_ctrl;
    localparam int DIVW   = 2;
    localparam int WIN    = 5;
    localparam int CW     = 3;
    localparam int STW    = 4;
    localparam int PER    = WIN * (1 << DIVW);
    localparam int FIRST  = 1 + PER;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clock_sys = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [2:0]    hall_effect = 3'b001;
    logic          fault_clear = 1'b0;
    logic [CW-1:0] comm_count;
    logic          count_valid, window_busy, stall, hall_fault, direction;

    int vectors = 0;
    int miscompares = 0;
    int pulse_count = 0;

    speed_window_ctrl #(.DIV_WIDTH(DIVW), .WINDOW(WIN), .CWIDTH(CW), .STALL_WINDOWS(STW)) dut (
        .clock_sys(clock_sys), .reset(reset), .enable(enable), .hall_effect(hall_effect),
        .fault_clear(fault_clear), .comm_count(comm_count), .count_valid(count_valid),
        .window_busy(window_busy), .stall(stall), .hall_fault(hall_fault), .direction(direction)
    );

    always #5 clock_sys = ~clock_sys;

    function automatic logic [2:0] ring(input int i);
        case (i % 6)
            0: ring = 3'd1;
            1: ring = 3'd3;
            2: ring = 3'd2;
            3: ring = 3'd6;
            4: ring = 3'd4;
            default: ring = 3'd5;
        endcase
    endfunction

    function automatic int pos(input logic [2:0] c);
        for (int i = 0; i < 6; i++)
            if (ring(i) == c) return i;
        return -1;
    endfunction

    // reference model: window membership decided purely by cycles since the enable edge
    bit            act = 0;
    int            age = 0, tally = 0, zrun = 0;
    logic [2:0]    mlast = 3'b000;
    logic [2:0]    pin_q[$];
    logic          e_cv = 0, e_busy = 0, e_stall = 0, e_fault = 0, e_dir = 0;
    logic [CW-1:0] e_cc = '0;

    initial begin
        forever begin
            @(posedge clock_sys or posedge reset);
            if (reset) begin
                act = 0; age = 0; tally = 0; zrun = 0; mlast = 3'b000; pin_q.delete();
                e_cv = 0; e_busy = 0; e_stall = 0; e_fault = 0; e_dir = 0; e_cc = '0;
            end else begin
                logic [2:0] v;
                bit vis, legal, evt, fset;
                vis   = (pin_q.size() >= 2);
                v     = vis ? pin_q[1] : 3'b000;
                legal = vis && v != 3'b000 && v != 3'b111;
                evt   = legal && v != mlast && mlast != 3'b000;
                fset  = vis && !legal;
`ifdef DIRECTION_EN
                if (evt) begin
                    int d;
                    d = (pos(v) - pos(mlast) + 6) % 6;
                    if (d == 1) e_dir = 1;
                    else if (d == 5) e_dir = 0;
                    else fset = 1;
                end
`endif
                if (legal) mlast = v;
                if (fset) e_fault = 1;
                else if (fault_clear) e_fault = 0;
                e_cv = 0;
                if (!enable) begin
                    act = 0; tally = 0; zrun = 0;
                end else if (!act) begin
                    act = 1; age = 0; tally = 0; zrun = 0;
                end else begin
                    if (age > 0) tally += int'(evt);
                    age++;
                    if (age >= FIRST && (age - FIRST) % PER == 0) begin
                        e_cv  = 1;
                        e_cc  = CW'((tally > CMAX) ? CMAX : tally);
                        zrun  = (tally == 0) ? ((zrun + 1 > STW) ? STW : zrun + 1) : 0;
                        tally = 0;
                    end
                end
                e_busy  = act && !e_cv;
                e_stall = (zrun == STW);
                pin_q.push_front(hall_effect);
                if (pin_q.size() > 2) void'(pin_q.pop_back());
            end
        end
    end

    initial begin
        @(posedge clock_sys);
        forever begin
            @(negedge clock_sys);
            vectors++;
            if (count_valid) pulse_count++;
            if (count_valid !== e_cv || comm_count !== e_cc || window_busy !== e_busy ||
                stall !== e_stall || hall_fault !== e_fault || direction !== e_dir) begin
                miscompares++;
                $display("FAIL cycle_compare t=%0t: got cv=%b cc=%0d busy=%b stall=%b fault=%b dir=%b, expected cv=%b cc=%0d busy=%b stall=%b fault=%b dir=%b",
                         $time, count_valid, comm_count, window_busy, stall, hall_fault, direction,
                         e_cv, e_cc, e_busy, e_stall, e_fault, e_dir);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock_sys);
        #2;
    endtask

    task automatic wait_pulse(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            edges(1);
            if (count_valid) ok = 1;
        end
        if (!ok) chk("pulse_timeout", 0, 1);
    endtask

    int exp_dir;
    int cur;
    int hold;
    int p0;

    initial begin
        exp_dir = 0;
`ifdef DIRECTION_EN
        exp_dir = 1;
`endif
        edges(3);
        chk("reset_cv", int'(count_valid), 0);
        chk("reset_cc", int'(comm_count), 0);
        chk("reset_busy", int'(window_busy), 0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_fault", int'(hall_fault), 0);
        chk("reset_dir", int'(direction), 0);
        reset = 1'b0;
        edges(3);
        chk("no_fault_after_reset", int'(hall_fault), 0);

        // idle motor: zero-count windows, stall after the fourth
        enable = 1'b1;
        edges(21);
        chk("first_window_not_yet", int'(count_valid), 0);
        chk("busy_in_measure", int'(window_busy), 1);
        edges(1);
        chk("first_pulse_at_21", int'(count_valid), 1);
        chk("first_count_zero", int'(comm_count), 0);
        edges(20);
        chk("second_pulse_at_20", int'(count_valid), 1);
        edges(20);
        chk("third_pulse", int'(count_valid), 1);
        chk("no_stall_after_3", int'(stall), 0);
        edges(20);
        chk("fourth_pulse", int'(count_valid), 1);
        chk("stall_after_4", int'(stall), 1);

        // six forward codes starting at the held code: five edges
        for (int i = 0; i < 6; i++) begin hall_effect = ring(i); edges(2); end
        wait_pulse(30);
        chk("five_forward_edges", int'(comm_count), 5);
        chk("stall_cleared", int'(stall), 0);
        for (int i = 0; i < 6; i++) begin hall_effect = ring(i); edges(2); end
        wait_pulse(30);
        chk("six_forward_edges", int'(comm_count), 6);
        chk("direction_forward", int'(direction), exp_dir);

        // illegal code: fault, not counted, cleared by fault_clear
        hall_effect = 3'b111; edges(2);
        hall_effect = 3'b101; edges(4);
        chk("illegal_sets_fault", int'(hall_fault), 1);
        wait_pulse(30);
        chk("illegal_not_counted", int'(comm_count), 0);
        fault_clear = 1'b1; edges(1); fault_clear = 1'b0;
        chk("fault_cleared", int'(hall_fault), 0);

        // saturation
        wait_pulse(30);
        for (int i = 0; i < 10; i++) begin hall_effect = ring(i); edges(1); end
        wait_pulse(30);
        chk("count_saturates", int'(comm_count), 7);

        // partial window discarded on enable drop
        wait_pulse(30);
        edges(5);
        p0 = pulse_count;
        enable = 1'b0;
        edges(1);
        chk("idle_not_busy", int'(window_busy), 0);
        edges(10);
        chk("no_partial_pulse", pulse_count - p0, 0);
        enable = 1'b1;
        edges(21);
        chk("reenable_not_yet", int'(count_valid), 0);
        edges(1);
        chk("reenable_pulse_21", int'(count_valid), 1);

        // skipped state
        hall_effect = 3'b100; edges(4);
        hall_effect = 3'b101; edges(4);
        hall_effect = 3'b001; edges(4);
        chk("dir_before_skip", int'(direction), exp_dir);
        fault_clear = 1'b1; edges(1); fault_clear = 1'b0;
        chk("fault_clear_before_skip", int'(hall_fault), 0);
        hall_effect = 3'b010; edges(4);
        chk("skip_fault", int'(hall_fault), exp_dir);
        chk("skip_dir_unchanged", int'(direction), exp_dir);

        // random traffic
        cur = 2;
        hold = 0;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                int r;
                r = int'($urandom_range(99));
                if (r < 60) cur = (cur + 1) % 6;
                else if (r < 75) cur = (cur + 5) % 6;
                else if (r < 82) cur = (cur + 2) % 6;
                hall_effect = ring(cur);
                if (r >= 82 && r < 88) hall_effect = ($urandom_range(1) == 0) ? 3'b000 : 3'b111;
                hold = ($urandom_range(9) == 0) ? int'($urandom_range(80, 20)) : int'($urandom_range(4, 1));
            end else begin
                hold--;
            end
            fault_clear = ($urandom_range(29) == 0);
            if (enable && $urandom_range(199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(15) == 0) enable = 1'b1;
            if ($urandom_range(999) == 0) begin
                reset = 1'b1; edges(2); reset = 1'b0;
            end
            edges(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/speed_window_ctrl.md
Name: speed_window_ctrl

Overview:
Controls the measurement window for hall-based BLDC speed measurement. It synchronises the three hall inputs, counts valid commutations inside a fixed-length gate window, and latches the total once per window with a one-cycle valid strobe. It also flags stalls and illegal hall codes. It sits between the hall pins and the rpm lookup / speed consumer.

Parameters:
DIV_WIDTH, 13, prescaler width; one window tick every 2^DIV_WIDTH clocks
WINDOW, 435, window length in ticks (must be >= 2)
CWIDTH, 11, width of the commutation count
STALL_WINDOWS, 4, consecutive zero-count windows before stall asserts (>= 1)

Ports:
clock_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run measurement; low forces IDLE
hall_effect  in  3  raw hall sensor code (asynchronous)
fault_clear  in  1  synchronous clear of sticky hall_fault
comm_count  out  CWIDTH  commutations latched in the last completed window
count_valid  out  1  one-cycle pulse when comm_count updates
window_busy  out  1  high in ARM and MEASURE
stall  out  1  STALL_WINDOWS consecutive zero-count windows
hall_fault  out  1  sticky; an illegal hall code (000 or 111) was seen
direction  out  1  1 = forward rotation (DIRECTION_EN only)

Behaviour:
- Reset: every output is 0; FSM = IDLE; prescaler, tick, commutation and stall counters are 0; sync flops are 0; last_valid_code = 000 (none).
- Hall path: 2-flop synchroniser, then a registered copy. An edge is a synced code that is legal (001..110) and differs from last_valid_code, with last_valid_code != 000. On any legal code, last_valid_code updates to it. Codes 000 and 111 set hall_fault, are not counted, and do not update last_valid_code. The synchroniser runs in all states, so edges are first counted 3 cycles after the pin change.
- FSM states: IDLE, ARM, MEASURE, LATCH.
- IDLE: counters held at 0 and stall counter cleared; comm_count is held. Goes to ARM when enable=1.
- ARM: lasts one cycle; clears prescaler, tick and commutation counters; then MEASURE.
- MEASURE: the prescaler free-runs and tick fires when it is all ones. When tick fires with tick_cnt == WINDOW-1, go to LATCH; otherwise tick_cnt increments. Each edge increments the commutation counter, which saturates at 2^CWIDTH-1.
- LATCH: lasts one cycle. comm_count <= commutation counter; count_valid = 1; counters restart from 0; returns to MEASURE. An edge arriving in the LATCH cycle counts toward the new window (new count starts at 1). Window period is exactly WINDOW*2^DIV_WIDTH clocks LATCH-to-LATCH. The first window is ARM + WINDOW*2^DIV_WIDTH cycles.
- Stall: on each LATCH, a zero count increments the stall counter (saturating at STALL_WINDOWS) and a nonzero count clears it. stall = (stall counter == STALL_WINDOWS).
- enable=0 in any state: go to IDLE on the next clock. A partial window is discarded, no count_valid is issued, and stall clears.
- fault_clear and a new illegal code in the same cycle: hall_fault stays 1.
- Reset mid-window: immediate return to reset values; no count_valid.

Optional Feature:
DIRECTION_EN. Forward sequence is 001->011->010->110->100->101->001.
- With the macro: on each edge, a forward-adjacent step sets direction=1 and a reverse-adjacent step sets direction=0. A non-adjacent jump (skipped state) sets hall_fault, leaves direction unchanged, and is still counted.
- Without the macro: direction is tied to 0 and skip jumps are not flagged.

Test Plan:
- Use DIV_WIDTH=2, WINDOW=5 (20-clock window). Reset, enable=1, no hall change -> count_valid pulses every 20 clocks with comm_count=0; stall=1 after the 4th window.
- Drive 6 forward codes spaced 2 clocks apart within one window -> comm_count=5 (first code has no predecessor); next window 6 -> stall clears and, with DIRECTION_EN, direction=1.
- Drive code 111 once -> hall_fault=1 and not counted; fault_clear pulse -> hall_fault=0.
- CWIDTH=3 with 10 edges in a window -> comm_count saturates at 7.
- Drop enable mid-window, then re-raise -> no count_valid for the partial window; window_busy=0 in IDLE; next pulse arrives 21 clocks after re-enable.
- With DIRECTION_EN, drive 001->010 (skip) -> hall_fault=1, edge counted, direction unchanged.
